writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
//  Owns the single register-file write port. Arbitrates between the in-order pipeline writeback
//  (ALU/load/LUI/jump result from the writeback mux) and late results from a multi-cycle unit.
//  Late results are buffered in a small FIFO. A starvation limit guarantees forward progress.
//  Keeps a scoreboard of destination registers owed by long-latency ops, for decode hazard checks.
// PARAMETERS
//  FIFO_DEPTH  2   late-result buffer entries (>=1)
//  MAX_WAIT    4   cycles a non-empty FIFO head may lose before it forces a pipeline stall (>=1)
// PORTS
//  clk               in   1   clock, rising edge
//  reset             in   1   synchronous, active-high
//  wb_valid          in   1   pipeline has a result this cycle
//  wb_rd             in   5   pipeline destination register
//  wb_data           in   32  pipeline result (word_t)
//  pipeline_stall    out  1   pipeline write not taken this cycle; hold wb_*
//  late_valid        in   1   multi-cycle unit offers a result
//  late_ready        out  1   FIFO accepts the offered result
//  late_rd           in   5   late-result destination
//  late_data         in   32  late result (word_t)
//  issue_valid       in   1   a long-latency op is issued this cycle
//  issue_rd          in   5   its destination register
//  pending_mask      out  32  bit r = 1: register r awaits a late write
//  rf_write_enable   out  1   register-file write strobe
//  rf_write_address  out  5   register-file write index
//  rf_write_data     out  32  register-file write data
// BEHAVIOUR
//  Reset: FIFO empty, starve counter 0, pending_mask 0, rf_write_* 0. late_ready is 1 after reset.
//  FIFO: late_ready = !full (registered occupancy, not combinational on pop).
//   - Push when late_valid && late_ready. No bypass: a pushed entry is eligible next cycle.
//  Select (combinational, evaluated each cycle):
//   1) FIFO non-empty && starve >= MAX_WAIT -> FIFO head; pipeline_stall = wb_valid
//   2) else wb_valid                        -> pipeline; pipeline_stall = 0
//   3) else FIFO non-empty                  -> FIFO head (pop)
//   4) else                                 -> no write
//  Starve counter:
//   - 0 when FIFO empty or head popped this cycle.
//   - Otherwise +1, saturating at MAX_WAIT.
//   - Width $clog2(MAX_WAIT+1).
//  RF port is registered: a selected write appears on rf_write_* the next cycle.
//   - rf_write_enable = selected && rd != 0; x0 writes are dropped.
//   - Latency: pipeline write 1 cycle; late write >= 2 cycles after the push.
//   - rf_write_address/data are don't-care when enable = 0, and hold their last value.
//  Scoreboard:
//   - Set bit issue_rd when issue_valid && issue_rd != 0.
//   - Clear bit rd when its FIFO entry is popped.
//   - Same-cycle set and clear of the same rd: set wins.
//   - Bit 0 is always 0. Pipeline writes never touch the scoreboard.
//   - Decode, not this block, prevents WAW/RAW against pending_mask.
//  Simultaneous events:
//   - Push + pop in the same cycle keeps occupancy unchanged.
//   - Push into a full FIFO is impossible (late_ready = 0).
//  Reset mid-operation discards buffered late results and clears the scoreboard. The late unit is reset too.
// STRUCTURE
//  riscv_package additions:
//   - register_index_t (logic [4:0])
//   - writeback_request_t struct {register_index_t rd; word_t data;}
//  Sub-module writeback_fifo: synchronous FIFO of writeback_request_t.
//   - Params DEPTH; ports push/pop/full/empty/head.
//  Arbiter, starve counter, scoreboard and output register stay in writeback_arbiter.
// TESTING
//  1 Reset asserted 2 cycles -> rf_write_enable=0, pending_mask=0, late_ready=1, pipeline_stall=0.
//  2 wb_valid, rd=5, data=0xDEADBEEF, 1 cycle -> next cycle en=1, addr=5, data=0xDEADBEEF.
//    Same with rd=0 -> en stays 0.
//  3 issue rd=7 -> mask[7]=1.
//    Then late push rd=7, data=0x1234 with pipeline idle -> RF write 2 cycles after the push.
//    mask[7] clears on the pop cycle.
//  4 Pipeline wb_valid every cycle; one late entry pushed at cycle t:
//    - pipeline_stall=1 exactly at cycle t+1+MAX_WAIT (t+5), with the late write on RF at t+6.
//    - Then the pipeline resumes and the counter returns to 0.
//  5 Pipeline busy, late unit pushes 3 back-to-back -> late_ready=0 after 2 pushes.
//    - Third held until a pop.
//    - All three reach the RF in push order, none lost or duplicated.
//  6 issue rd=9 in the same cycle as pop of the pending rd=9 -> mask[9] stays 1.
//    Reset while FIFO holds 2 entries -> FIFO empty, no RF write after reset.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the register-file writeback path.
package writeback_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  register_index_t;

  typedef struct packed {
    register_index_t rd;
    word_t           data;
  } writeback_request_t;

  localparam int unsigned NUM_REGS = 32;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: pipeline result, late-result offer, long-latency issue
// and the register-file write port. The master side (pipeline / late unit / decode)
// drives requests; the slave side (the arbiter) answers and owns the RF port.
interface writeback_arbiter_if;
  import writeback_arbiter_pkg::*;

  logic            wb_valid;
  register_index_t wb_rd;
  word_t           wb_data;
  logic            pipeline_stall;

  logic            late_valid;
  logic            late_ready;
  register_index_t late_rd;
  word_t           late_data;

  logic            issue_valid;
  register_index_t issue_rd;
  logic [31:0]     pending_mask;

  logic            rf_write_enable;
  register_index_t rf_write_address;
  word_t           rf_write_data;

  modport master (
    output wb_valid, wb_rd, wb_data,
    input  pipeline_stall,
    output late_valid, late_rd, late_data,
    input  late_ready,
    output issue_valid, issue_rd,
    input  pending_mask,
    input  rf_write_enable, rf_write_address, rf_write_data
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    output pipeline_stall,
    input  late_valid, late_rd, late_data,
    output late_ready,
    input  issue_valid, issue_rd,
    output pending_mask,
    output rf_write_enable, rf_write_address, rf_write_data
  );
endinterface

// File: rtl/writeback_arbiter_fifo.sv
// Small synchronous FIFO holding late writeback requests. Full/empty come from
// registered occupancy only, so a same-cycle pop never frees a slot early.
module writeback_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_push,
  input  writeback_request_t i_push_data,
  input  logic               i_pop,
  output logic               o_full,
  output logic               o_empty,
  output writeback_request_t o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  writeback_request_t r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (i_pop && !i_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Owns the single register-file write port. Pipeline results normally win;
// buffered late results take idle cycles, and a starvation counter forces the
// FIFO head through (stalling the pipeline) once it has lost MAX_WAIT times.
// Also tracks destinations owed by long-latency ops for decode hazard checks.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input logic                i_clk,
  input logic                i_reset,
  writeback_arbiter_if.slave if_wb
);

  localparam int STARVE_W = $clog2(MAX_WAIT + 1);

  logic                 w_full;
  logic                 w_empty;
  writeback_request_t   w_head;
  writeback_request_t   w_push_data;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_force;
  logic                 w_sel_pipe;
  writeback_request_t   w_sel_req;
  logic                 w_sel_valid;
  logic [31:0]          w_set_mask;
  logic [31:0]          w_clr_mask;

  logic [STARVE_W-1:0]  r_starve;
  logic [31:0]          r_pending;
  logic                 r_rf_we;
  register_index_t      r_rf_addr;
  word_t                r_rf_data;

  assign w_push_data = '{rd: if_wb.late_rd, data: if_wb.late_data};
  assign w_push      = if_wb.late_valid && !w_full;

  writeback_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head)
  );

  // Port selection: forced FIFO head, else pipeline, else FIFO head on an idle cycle.
  always_comb begin
    w_force     = !w_empty && (r_starve >= STARVE_W'(MAX_WAIT));
    w_pop       = 1'b0;
    w_sel_pipe  = 1'b0;
    w_sel_valid = 1'b0;
    w_sel_req   = '{rd: if_wb.wb_rd, data: if_wb.wb_data};
    if (w_force || (!if_wb.wb_valid && !w_empty)) begin
      w_pop       = 1'b1;
      w_sel_valid = 1'b1;
      w_sel_req   = w_head;
    end else if (if_wb.wb_valid) begin
      w_sel_pipe  = 1'b1;
      w_sel_valid = 1'b1;
    end
  end

  // Scoreboard update terms; a same-cycle issue to the popped rd keeps the bit set.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (if_wb.issue_valid && (if_wb.issue_rd != '0)) begin
      w_set_mask = 32'(1) << if_wb.issue_rd;
    end
    if (w_pop) begin
      w_clr_mask = 32'(1) << w_head.rd;
    end
  end

  assign if_wb.late_ready     = !w_full;
  assign if_wb.pipeline_stall = w_force && if_wb.wb_valid;
  assign if_wb.pending_mask   = r_pending;

  // Starvation counter: counts cycles a waiting head loses, saturating at MAX_WAIT.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_starve <= '0;
    end else if (w_empty || w_pop) begin
      r_starve <= '0;
    end else if (r_starve < STARVE_W'(MAX_WAIT)) begin
      r_starve <= r_starve + STARVE_W'(1);
    end
  end

  // Pending-destination scoreboard; x0 is never owed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'(1);
    end
  end

  // Registered RF port; x0 writes are dropped and address/data hold otherwise.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rf_we   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
    end else begin
      r_rf_we <= w_sel_valid && (w_sel_req.rd != '0);
      if (w_sel_valid && (w_sel_req.rd != '0)) begin
        r_rf_addr <= w_sel_req.rd;
        r_rf_data <= w_sel_req.data;
      end
    end
  end

  assign if_wb.rf_write_enable  = r_rf_we;
  assign if_wb.rf_write_address = r_rf_addr;
  assign if_wb.rf_write_data    = r_rf_data;

  logic w_unused;
  assign w_unused = w_sel_pipe;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed scenarios followed by a randomized run, all checked against a
// queue-based reference model of the writeback rules.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int MAXW  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  writeback_arbiter_if bus();

  writeback_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .if_wb   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  writeback_request_t mq[$];
  int                 m_starve;
  logic [31:0]        m_mask;
  logic               m_en;
  logic [4:0]         m_addr;
  logic [31:0]        m_data;

  logic               obs_stall;
  logic               obs_ready;
  logic [4:0]         wlog[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int n;
    logic force_late;
    logic take_late;
    logic popped;
    writeback_request_t it;
    #1;
    n = mq.size();
    force_late = (n > 0) && (m_starve >= MAXW);
    obs_stall = bus.pipeline_stall;
    obs_ready = bus.late_ready;
    if (!reset) begin
      check("late_ready", obs_ready, (n < DEPTH));
      check("pipeline_stall", obs_stall, force_late && bus.wb_valid);
    end
    if (reset) begin
      mq.delete();
      m_starve = 0; m_mask = 0; m_en = 0; m_addr = 0; m_data = 0;
    end else begin
      popped = 0;
      take_late = force_late || (!bus.wb_valid && n > 0);
      m_en = 0;
      if (take_late) begin
        it = mq.pop_front();
        popped = 1;
        m_mask[it.rd] = 1'b0;
        if (it.rd != 0) begin m_en = 1; m_addr = it.rd; m_data = it.data; end
      end else if (bus.wb_valid && bus.wb_rd != 0) begin
        m_en = 1; m_addr = bus.wb_rd; m_data = bus.wb_data;
      end
      if (bus.late_valid && n < DEPTH) mq.push_back('{rd: bus.late_rd, data: bus.late_data});
      if (n == 0 || popped) m_starve = 0;
      else if (m_starve < MAXW) m_starve++;
      if (bus.issue_valid && bus.issue_rd != 0) m_mask[bus.issue_rd] = 1'b1;
      m_mask[0] = 1'b0;
    end
    @(posedge clk);
    #1;
    check("rf_write_enable", bus.rf_write_enable, m_en);
    if (m_en) begin
      check("rf_write_address", bus.rf_write_address, m_addr);
      check("rf_write_data", bus.rf_write_data, m_data);
    end
    check("pending_mask", bus.pending_mask, m_mask);
    if (bus.rf_write_enable) wlog.push_back(bus.rf_write_address);
  endtask

  task automatic idle_inputs();
    bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.late_valid = 0; bus.late_rd = 0; bus.late_data = 0;
    bus.issue_valid = 0; bus.issue_rd = 0;
  endtask

  initial begin
    int k;
    int pushed;
    logic [4:0] exp_order[$];
    logic [4:0] late_order[$];

    idle_inputs();
    reset = 1;
    m_starve = 0; m_mask = 0; m_en = 0; m_addr = 0; m_data = 0;

    // 1: reset for two cycles
    step(); step();
    reset = 0;
    #1;
    check("rst_en", bus.rf_write_enable, 0);
    check("rst_mask", bus.pending_mask, 0);
    check("rst_ready", bus.late_ready, 1);
    check("rst_stall", bus.pipeline_stall, 0);

    // 2: pipeline write, then an x0 write
    bus.wb_valid = 1; bus.wb_rd = 5; bus.wb_data = 32'hDEADBEEF;
    step();
    check("wb5_en", bus.rf_write_enable, 1);
    check("wb5_addr", bus.rf_write_address, 5);
    check("wb5_data", bus.rf_write_data, 32'hDEADBEEF);
    bus.wb_rd = 0; bus.wb_data = 32'h11111111;
    step();
    check("wb0_en", bus.rf_write_enable, 0);
    idle_inputs();

    // 3: issue rd7, late push, pop on the following idle cycle
    bus.issue_valid = 1; bus.issue_rd = 7;
    step();
    check("mask7_set", bus.pending_mask[7], 1);
    idle_inputs();
    bus.late_valid = 1; bus.late_rd = 7; bus.late_data = 32'h1234;
    step();
    idle_inputs();
    check("late7_not_yet", bus.rf_write_enable, 0);
    check("mask7_held", bus.pending_mask[7], 1);
    step();
    check("late7_en", bus.rf_write_enable, 1);
    check("late7_addr", bus.rf_write_address, 7);
    check("late7_data", bus.rf_write_data, 32'h1234);
    check("mask7_clr", bus.pending_mask[7], 0);

    // 4: busy pipeline starves one late entry until the forced slot
    bus.wb_valid = 1; bus.wb_rd = 3; bus.wb_data = 32'hA0;
    bus.late_valid = 1; bus.late_rd = 12; bus.late_data = 32'hCAFE;
    step();
    bus.late_valid = 0;
    for (k = 1; k <= 8; k++) begin
      if (!obs_stall || k == 1) bus.wb_data = 32'hA0 + 32'(k);
      step();
      check("starve_stall", obs_stall, (k == MAXW + 1));
      if (k == MAXW + 1) begin
        check("forced_addr", bus.rf_write_address, 12);
        check("forced_data", bus.rf_write_data, 32'hCAFE);
      end
    end
    idle_inputs();
    step();

    // 5: three back-to-back late pushes with the pipeline busy
    wlog.delete();
    late_order = '{5'd20, 5'd21, 5'd22};
    bus.wb_valid = 1; bus.wb_rd = 3; bus.wb_data = 32'h33;
    pushed = 0;
    for (k = 0; k < 40 && pushed < 3; k++) begin
      bus.late_valid = 1; bus.late_rd = late_order[pushed]; bus.late_data = 32'h500 + 32'(pushed);
      step();
      if (k == 2) check("third_blocked", obs_ready, 0);
      if (obs_ready) pushed++;
    end
    check("all_pushed", pushed, 3);
    bus.late_valid = 0;
    bus.wb_valid = 0;
    for (k = 0; k < 6; k++) step();
    exp_order.delete();
    foreach (wlog[i]) if (wlog[i] >= 20) exp_order.push_back(wlog[i]);
    check("late_count", exp_order.size(), 3);
    for (int i = 0; i < 3 && i < exp_order.size(); i++) check("late_order", exp_order[i], late_order[i]);

    // 6: set wins over same-cycle clear, then reset with a full FIFO
    idle_inputs();
    bus.issue_valid = 1; bus.issue_rd = 9;
    step();
    idle_inputs();
    bus.late_valid = 1; bus.late_rd = 9; bus.late_data = 32'h99;
    step();
    idle_inputs();
    bus.issue_valid = 1; bus.issue_rd = 9;
    step();
    check("mask9_setwins", bus.pending_mask[9], 1);
    check("late9_addr", bus.rf_write_address, 9);
    idle_inputs();
    bus.wb_valid = 1; bus.wb_rd = 3; bus.wb_data = 32'h77;
    bus.late_valid = 1; bus.late_rd = 14; bus.late_data = 32'hE;
    step();
    bus.late_rd = 15; bus.late_data = 32'hF;
    step();
    bus.late_valid = 0;
    check("full_before_rst", bus.late_ready, 0);
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    check("rst_ready2", bus.late_ready, 1);
    check("rst_mask2", bus.pending_mask, 0);
    for (k = 0; k < 4; k++) begin
      step();
      check("no_write_after_rst", bus.rf_write_enable, 0);
    end

    // randomized run
    for (k = 0; k < 600; k++) begin
      reset = ($urandom_range(0, 149) == 0);
      if (!obs_stall) begin
        bus.wb_valid = ($urandom_range(0, 2) != 0);
        bus.wb_rd = 5'($urandom_range(0, 31));
        bus.wb_data = $urandom;
      end
      if (!bus.late_valid && $urandom_range(0, 2) == 0) begin
        bus.late_valid = 1;
        bus.late_rd = 5'($urandom_range(0, 31));
        bus.late_data = $urandom;
      end
      bus.issue_valid = ($urandom_range(0, 3) == 0);
      bus.issue_rd = 5'($urandom_range(0, 31));
      step();
      if (reset || (bus.late_valid && obs_ready)) bus.late_valid = 0;
    end
    reset = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
